// File: rtl/ddr_line_read_controller.sv
// Fetches one display line per request from the DDR frame buffer and streams the
// returned beats into the display line FIFO, tracking line address and line count.
module ddr_line_read_controller #(
  parameter int g_DDR_AXI_DWIDTH = 512,
  parameter int g_PIXEL_DWIDTH   = 32
) (
  input  logic                        sys_clk_i,
  input  logic                        rstn_i,
  input  logic [15:0]                 c_LINE_GAP,
  input  logic                        frame_start_i,
  input  logic                        line_req_i,
  input  logic [15:0]                 horiz_resolution_i,
  input  logic [37:0]                 frame_ddr_addr_i,
  input  logic                        read_ackn_i,
  input  logic                        read_done_i,
  input  logic                        rdata_valid_i,
  input  logic [g_DDR_AXI_DWIDTH-1:0] rdata_i,
  output logic                        read_req_o,
  output logic [37:0]                 read_start_addr_o,
  output logic [7:0]                  read_length_o,
  output logic                        fifo_we_o,
  output logic [g_DDR_AXI_DWIDTH-1:0] fifo_wdata_o,
  output logic                        busy_o,
  output logic [15:0]                 line_count_o,
  output logic                        missed_req_o,
  output logic                        overflow_err_o
);

  localparam int c_PPB   = g_DDR_AXI_DWIDTH / g_PIXEL_DWIDTH;
  localparam int c_SHIFT = $clog2(c_PPB);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_READING = 2'd2,
    S_BAD     = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_fs_dly1, r_fs_dly2, r_lr_dly1, r_lr_dly2;
  logic [37:0] r_line_addr;
  logic [15:0] r_beats_max;
  logic [15:0] r_beat_cnt;
  logic        r_pend_frame;
  logic [7:0]  r_len;

  logic        w_frame_edge;
  logic        w_line_edge;
  logic [15:0] w_beats;
  logic        w_beat_ok;

  assign w_frame_edge      = r_fs_dly1 & ~r_fs_dly2;
  assign w_line_edge       = r_lr_dly1 & ~r_lr_dly2;
  assign w_beats           = horiz_resolution_i >> c_SHIFT;
  assign w_beat_ok         = (r_beat_cnt < r_beats_max);
  assign read_start_addr_o = r_line_addr;
  assign read_length_o     = r_len;
  assign busy_o            = (r_state != S_IDLE);

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state        <= S_IDLE;
      r_fs_dly1      <= 1'b0;
      r_fs_dly2      <= 1'b0;
      r_lr_dly1      <= 1'b0;
      r_lr_dly2      <= 1'b0;
      r_line_addr    <= '0;
      r_beats_max    <= '0;
      r_beat_cnt     <= '0;
      r_pend_frame   <= 1'b0;
      r_len          <= '0;
      read_req_o     <= 1'b0;
      fifo_we_o      <= 1'b0;
      fifo_wdata_o   <= '0;
      line_count_o   <= '0;
      missed_req_o   <= 1'b0;
      overflow_err_o <= 1'b0;
    end else begin
      r_fs_dly1    <= frame_start_i;
      r_fs_dly2    <= r_fs_dly1;
      r_lr_dly1    <= line_req_i;
      r_lr_dly2    <= r_lr_dly1;
      missed_req_o <= 1'b0;
      fifo_we_o    <= 1'b0;

      // Requests arriving mid-line are reported and dropped, never queued
      if (r_state != S_IDLE) begin
        if (w_line_edge)  missed_req_o <= 1'b1;
        if (w_frame_edge) r_pend_frame <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          read_req_o <= 1'b0;
          r_beat_cnt <= '0;
          // Frame start lands first so a coincident line request reads from the new base
          if (w_frame_edge) begin
            r_line_addr    <= frame_ddr_addr_i;
            line_count_o   <= '0;
            overflow_err_o <= 1'b0;
          end
          if (w_line_edge) begin
            r_beats_max <= w_beats;
            r_len       <= w_beats[7:0] - 8'd1;
            if (w_beats != 16'd0) r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (read_ackn_i) begin
            read_req_o <= 1'b0;
            r_state    <= S_READING;
          end else begin
            read_req_o <= 1'b1;
          end
        end
        S_READING: begin
          if (rdata_valid_i) begin
            if (w_beat_ok) begin
              fifo_we_o    <= 1'b1;
              fifo_wdata_o <= rdata_i;
              r_beat_cnt   <= r_beat_cnt + 16'd1;
            end else begin
              overflow_err_o <= 1'b1;
            end
          end
          // A deferred frame start replaces the normal address step at end of line
          if (read_done_i) begin
            r_state <= S_IDLE;
            if (r_pend_frame || w_frame_edge) begin
              r_line_addr    <= frame_ddr_addr_i;
              line_count_o   <= '0;
              overflow_err_o <= 1'b0;
              r_pend_frame   <= 1'b0;
            end else begin
              r_line_addr  <= r_line_addr + {22'd0, c_LINE_GAP};
              line_count_o <= line_count_o + 16'd1;
            end
          end
        end
        default: begin
          read_req_o <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_line_read_controller.sv
// Scoreboard bench for ddr_line_read_controller: line fetch, FIFO stream, overflow,
// deferred frame start, dropped requests, zero-width lines and address wrap.
module tb_ddr_line_read_controller;
  localparam int DW = 512;

  logic          sys_clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [15:0]   c_LINE_GAP = 16'h2000;
  logic          frame_start_i = 1'b0;
  logic          line_req_i = 1'b0;
  logic [15:0]   horiz_resolution_i = 16'd1920;
  logic [37:0]   frame_ddr_addr_i = '0;
  logic          read_ackn_i = 1'b0;
  logic          read_done_i = 1'b0;
  logic          rdata_valid_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;
  logic          read_req_o;
  logic [37:0]   read_start_addr_o;
  logic [7:0]    read_length_o;
  logic          fifo_we_o;
  logic [DW-1:0] fifo_wdata_o;
  logic          busy_o;
  logic [15:0]   line_count_o;
  logic          missed_req_o;
  logic          overflow_err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_writes = 0;
  int n_miss_hi = 0;
  int n_req_rise = 0;
  bit busy_seen = 0;
  bit prev_req = 0;
  logic [DW-1:0] q_data[$];
  int            q_cyc[$];

  ddr_line_read_controller #(.g_DDR_AXI_DWIDTH(DW), .g_PIXEL_DWIDTH(32)) dut (
    .sys_clk_i(sys_clk_i), .rstn_i(rstn_i), .c_LINE_GAP(c_LINE_GAP),
    .frame_start_i(frame_start_i), .line_req_i(line_req_i),
    .horiz_resolution_i(horiz_resolution_i), .frame_ddr_addr_i(frame_ddr_addr_i),
    .read_ackn_i(read_ackn_i), .read_done_i(read_done_i),
    .rdata_valid_i(rdata_valid_i), .rdata_i(rdata_i),
    .read_req_o(read_req_o), .read_start_addr_o(read_start_addr_o),
    .read_length_o(read_length_o), .fifo_we_o(fifo_we_o), .fifo_wdata_o(fifo_wdata_o),
    .busy_o(busy_o), .line_count_o(line_count_o), .missed_req_o(missed_req_o),
    .overflow_err_o(overflow_err_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  // FIFO-side monitor: every write must match the oldest expected beat and its cycle
  always @(negedge sys_clk_i) begin
    if (rstn_i && fifo_we_o) begin
      n_writes++;
      n_tests++;
      if (q_data.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_unexpected_write at cycle %0d, no beat expected", cyc);
      end else begin
        logic [DW-1:0] d;
        int c;
        d = q_data.pop_front();
        c = q_cyc.pop_front();
        if (fifo_wdata_o !== d || cyc !== c) begin
          n_fail++;
          $display("FAIL fifo_write data=%h cyc=%0d, required data=%h cyc=%0d",
                   fifo_wdata_o, cyc, d, c);
        end
      end
    end
    if (missed_req_o) n_miss_hi++;
    if (read_req_o && !prev_req) n_req_rise++;
    prev_req = read_req_o;
    if (busy_o) busy_seen = 1;
  end

  task automatic pulse_frame(input logic [37:0] base);
    frame_ddr_addr_i = base;
    frame_start_i = 1'b1;
    repeat (4) @(posedge sys_clk_i);
    #1 frame_start_i = 1'b0;
    repeat (3) @(posedge sys_clk_i);
    #1;
  endtask

  task automatic run_line(input logic [37:0] exp_addr, input int nbeats, input int nexp,
                          input bit miss, input bit mid_frame, input logic [37:0] mid_base);
    int t;
    int w0;
    logic [DW-1:0] d;
    w0 = n_writes;
    line_req_i = 1'b1;
    t = 0;
    while (read_req_o !== 1'b1 && t < 30) begin
      @(negedge sys_clk_i);
      t++;
    end
    n_tests++;
    if (read_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL read_req_timeout read_req_o=%b, required 1", read_req_o);
    end
    n_tests++;
    if (read_start_addr_o !== exp_addr) begin
      n_fail++;
      $display("FAIL read_start_addr got %h, required %h", read_start_addr_o, exp_addr);
    end
    n_tests++;
    if (read_length_o !== 8'd119) begin
      n_fail++;
      $display("FAIL read_length got %0d, required 119", read_length_o);
    end
    @(posedge sys_clk_i);
    #1 read_ackn_i = 1'b1;
    @(posedge sys_clk_i);
    #1 read_ackn_i = 1'b0;
    if (mid_frame) begin
      frame_ddr_addr_i = mid_base;
      frame_start_i = 1'b1;
    end
    if (miss) begin
      line_req_i = 1'b0;
      repeat (3) @(posedge sys_clk_i);
      #1 line_req_i = 1'b1;
      repeat (3) @(posedge sys_clk_i);
      #1;
    end
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      rdata_valid_i = 1'b1;
      rdata_i = d;
      if (b < nexp) begin
        q_data.push_back(d);
        q_cyc.push_back(cyc + 1);
      end
      @(posedge sys_clk_i);
      #1 rdata_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge sys_clk_i);
        #1;
      end
    end
    read_done_i = 1'b1;
    @(posedge sys_clk_i);
    #1 read_done_i = 1'b0;
    line_req_i = 1'b0;
    frame_start_i = 1'b0;
    repeat (4) @(posedge sys_clk_i);
    #1;
    n_tests++;
    if (n_writes - w0 !== nexp || q_data.size() != 0) begin
      n_fail++;
      $display("FAIL line_writes got %0d (pending %0d), required %0d",
               n_writes - w0, q_data.size(), nexp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk_i);
    #1;
    n_tests++;
    if ({read_req_o, fifo_we_o, busy_o, missed_req_o, overflow_err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b, required 00000",
               {read_req_o, fifo_we_o, busy_o, missed_req_o, overflow_err_o});
    end
    n_tests++;
    if (read_start_addr_o !== 38'd0 || read_length_o !== 8'd0 || line_count_o !== 16'd0
        || fifo_wdata_o !== '0) begin
      n_fail++;
      $display("FAIL reset_values addr=%h len=%0d lines=%0d, required all 0",
               read_start_addr_o, read_length_o, line_count_o);
    end
    rstn_i = 1'b1;
    repeat (2) @(posedge sys_clk_i);
    #1;
  endtask

  task automatic test_three_lines();
    pulse_frame(38'h1000);
    run_line(38'h1000, 120, 120, 0, 0, '0);
    run_line(38'h3000, 120, 120, 0, 0, '0);
    run_line(38'h5000, 120, 120, 0, 0, '0);
    n_tests++;
    if (line_count_o !== 16'd3) begin
      n_fail++;
      $display("FAIL line_count got %0d, required 3", line_count_o);
    end
  endtask

  task automatic test_overflow();
    run_line(38'h7000, 121, 120, 0, 0, '0);
    n_tests++;
    if (overflow_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set got %b, required 1", overflow_err_o);
    end
    pulse_frame(38'h1000);
    n_tests++;
    if (overflow_err_o !== 1'b0 || line_count_o !== 16'd0) begin
      n_fail++;
      $display("FAIL overflow_clear ovf=%b lines=%0d, required 0 and 0",
               overflow_err_o, line_count_o);
    end
  endtask

  task automatic test_frame_in_reading();
    run_line(38'h1000, 120, 120, 0, 1, 38'h8000);
    n_tests++;
    if (line_count_o !== 16'd0 || read_start_addr_o !== 38'h8000) begin
      n_fail++;
      $display("FAIL deferred_frame lines=%0d addr=%h, required 0 and 8000",
               line_count_o, read_start_addr_o);
    end
    run_line(38'h8000, 120, 120, 0, 0, '0);
    n_tests++;
    if (line_count_o !== 16'd1) begin
      n_fail++;
      $display("FAIL count_after_frame got %0d, required 1", line_count_o);
    end
  endtask

  task automatic test_missed_req();
    int m0, r0;
    m0 = n_miss_hi;
    r0 = n_req_rise;
    run_line(38'hA000, 120, 120, 1, 0, '0);
    repeat (6) @(posedge sys_clk_i);
    #1;
    n_tests++;
    if (n_miss_hi - m0 !== 1) begin
      n_fail++;
      $display("FAIL missed_pulse high cycles %0d, required 1", n_miss_hi - m0);
    end
    n_tests++;
    if (n_req_rise - r0 !== 1) begin
      n_fail++;
      $display("FAIL missed_bursts read requests %0d, required 1", n_req_rise - r0);
    end
  endtask

  task automatic test_zero_width_and_wrap();
    int r0;
    pulse_frame(38'h3F_FFFF_F000);
    horiz_resolution_i = 16'd8;
    r0 = n_req_rise;
    busy_seen = 0;
    line_req_i = 1'b1;
    repeat (8) @(negedge sys_clk_i);
    n_tests++;
    if (busy_seen !== 1'b0 || n_req_rise - r0 !== 0) begin
      n_fail++;
      $display("FAIL zero_width busy_seen=%b requests=%0d, required 0 and 0",
               busy_seen, n_req_rise - r0);
    end
    line_req_i = 1'b0;
    horiz_resolution_i = 16'd1920;
    repeat (4) @(posedge sys_clk_i);
    #1;
    run_line(38'h3F_FFFF_F000, 120, 120, 0, 0, '0);
    n_tests++;
    if (read_start_addr_o !== 38'h1000 || line_count_o !== 16'd1) begin
      n_fail++;
      $display("FAIL addr_wrap addr=%h lines=%0d, required 1000 and 1",
               read_start_addr_o, line_count_o);
    end
  endtask

  task automatic test_reset_mid_op();
    int t;
    line_req_i = 1'b1;
    t = 0;
    while (read_req_o !== 1'b1 && t < 30) begin
      @(negedge sys_clk_i);
      t++;
    end
    #2 rstn_i = 1'b0;
    #3;
    n_tests++;
    if (read_req_o !== 1'b0 || busy_o !== 1'b0 || read_start_addr_o !== 38'd0
        || line_count_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op req=%b busy=%b addr=%h lines=%0d, required all 0",
               read_req_o, busy_o, read_start_addr_o, line_count_o);
    end
    line_req_i = 1'b0;
    repeat (2) @(posedge sys_clk_i);
    #1 rstn_i = 1'b1;
    repeat (2) @(posedge sys_clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_three_lines();
    test_overflow();
    test_frame_in_reading();
    test_missed_req();
    test_zero_width_and_wrap();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
